// File: rtl/pe_seq_ctrl_if.sv
// Handshake and bus bundle between the layer controller, the sequencer and one PE.
// master: the sequencer; slave: controller/PE side.
interface pe_seq_ctrl_if #(
    parameter int COL_W = 8,
    parameter int ROW_W = 8
);
    logic             start;
    logic             cfg_kernel5;
    logic [COL_W-1:0] cfg_cols;
    logic [ROW_W-1:0] cfg_rows;
    logic             pe_fifo_full;
    logic             busy;
    logic             done;
    logic [2:0]       pe_state;
    logic [2:0]       pe_weight_mode;
    logic             pe_finish;
    logic             pe_end_of_row;
    logic             act_rd_en;
    logic             wgt_rd_en;
    logic [1:0]       wgt_sel;

    modport master (
        input  start, cfg_kernel5, cfg_cols, cfg_rows, pe_fifo_full,
        output busy, done, pe_state, pe_weight_mode, pe_finish,
        output pe_end_of_row, act_rd_en, wgt_rd_en, wgt_sel
    );

    modport slave (
        output start, cfg_kernel5, cfg_cols, cfg_rows, pe_fifo_full,
        input  busy, done, pe_state, pe_weight_mode, pe_finish,
        input  pe_end_of_row, act_rd_en, wgt_rd_en, wgt_sel
    );
endinterface

// File: rtl/pe_seq_ctrl.sv
// PE sequencer: walks rows x cols output steps with a 3x3 or split 5x5 kernel,
// issuing weight loads, activation reads and finish pulses; stalls on PE FIFO full.
module pe_seq_ctrl #(
    parameter int COL_W = 8,
    parameter int ROW_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_HOLD, S_FIN, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             k5_q, k5_d;
    logic [COL_W-1:0] cols_q, cols_d, col_q, col_d;
    logic [ROW_W-1:0] rows_q, rows_d, row_q, row_d;
    logic             parity_q, parity_d;
    logic             pass_q, pass_d;
    logic [2:0]       step_q, step_d;
    logic [2:0]       mode_q, mode_d;
    logic [1:0]       sel_q, sel_d;

    logic [1:0] load_sel;
    logic [2:0] load_mode;
    logic [2:0] k_last;
    logic       eor;
    logic       last_row;

    // 5x5 groups: parity picks A/B vs C/D, pass picks the half.
    assign load_sel  = k5_q ? {parity_q, pass_q} : 2'd0;
    assign load_mode = k5_q ? {1'b0, load_sel} + 3'd1 : 3'd0;
    assign k_last    = k5_q ? 3'd5 : 3'd3;
    assign eor       = (col_q == cols_q - COL_W'(1));
    assign last_row  = (row_q == rows_q - ROW_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k5_q     <= 1'b0;
            cols_q   <= '0;
            rows_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            parity_q <= 1'b0;
            pass_q   <= 1'b0;
            step_q   <= '0;
            mode_q   <= '0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            k5_q     <= k5_d;
            cols_q   <= cols_d;
            rows_q   <= rows_d;
            col_q    <= col_d;
            row_q    <= row_d;
            parity_q <= parity_d;
            pass_q   <= pass_d;
            step_q   <= step_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k5_d     = k5_q;
        cols_d   = cols_q;
        rows_d   = rows_q;
        col_d    = col_q;
        row_d    = row_q;
        parity_d = parity_q;
        pass_d   = pass_q;
        step_d   = step_q;
        mode_d   = mode_q;
        sel_d    = sel_q;
        unique case (state_q)
            S_IDLE: if (bus.start) begin
                k5_d     = bus.cfg_kernel5;
                cols_d   = (bus.cfg_cols == '0) ? COL_W'(1) : bus.cfg_cols;
                rows_d   = (bus.cfg_rows == '0) ? ROW_W'(1) : bus.cfg_rows;
                col_d    = '0;
                row_d    = '0;
                parity_d = 1'b0;
                pass_d   = 1'b0;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                step_d  = 3'd1;
                mode_d  = load_mode;
                sel_d   = load_sel;
                state_d = S_RUN;
            end
            S_RUN: if (step_q == k_last) begin
                if (k5_q && !pass_q) begin
                    pass_d  = 1'b1;
                    state_d = S_LOAD;
                end else if (parity_q && bus.pe_fifo_full) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_FIN;
                end
            end else begin
                step_d = step_q + 3'd1;
            end
            S_HOLD: if (!bus.pe_fifo_full) state_d = S_FIN;
            S_FIN: begin
                pass_d = 1'b0;
                if (eor) begin
                    parity_d = 1'b0;
                    col_d    = '0;
                    row_d    = row_q + ROW_W'(1);
                end else begin
                    parity_d = ~parity_q;
                    col_d    = col_q + COL_W'(1);
                end
                state_d = (eor && last_row) ? S_DONE : S_LOAD;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy           = (state_q != S_IDLE);
        bus.done           = (state_q == S_DONE);
        bus.pe_state       = (state_q == S_RUN) ? step_q : 3'd0;
        bus.act_rd_en      = (state_q == S_RUN);
        bus.wgt_rd_en      = (state_q == S_LOAD);
        bus.pe_finish      = (state_q == S_FIN);
        bus.pe_end_of_row  = (state_q == S_FIN) && eor;
        bus.pe_weight_mode = (state_q == S_LOAD) ? load_mode : mode_q;
        bus.wgt_sel        = (state_q == S_LOAD) ? load_sel : sel_q;
    end
endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: a per-job cycle schedule model, directed jobs,
// mid-job reset and randomized start/cfg/fifo_full traffic.
module tb_pe_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_seq_ctrl_if #(.COL_W(8), .ROW_W(8)) bus ();

    pe_seq_ctrl #(.COL_W(8), .ROW_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] mode;
        logic [1:0] sel;
        logic       ld;
        logic       act;
        logic       fin;
        logic       eor;
        logic       dn;
        logic       hchk;
    } desc_t;

    desc_t      sched[$];
    desc_t      cur;
    bit         m_busy;
    logic [2:0] last_mode;
    logic [1:0] last_sel;

    int n_chk = 0;
    int n_fail = 0;

    int cyc, fins, acts, first_fin, last_fin, done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        cur = '0;
        m_busy = 0;
        last_mode = '0;
        last_sel = '0;
    endtask

    // One column step = (LOAD, K RUN)x passes, then FIN; parity is column oddness.
    task automatic model_build(input bit k5, input int cols, input int rows);
        int ce, re, k, np;
        desc_t d;
        ce = (cols == 0) ? 1 : cols;
        re = (rows == 0) ? 1 : rows;
        k  = k5 ? 5 : 3;
        np = k5 ? 2 : 1;
        for (int r = 0; r < re; r++)
            for (int c = 0; c < ce; c++) begin
                for (int p = 0; p < np; p++) begin
                    d = '0;
                    d.ld = 1;
                    d.sel = k5 ? 2'((c % 2) * 2 + p) : 2'd0;
                    d.mode = k5 ? 3'(1 + d.sel) : 3'd0;
                    sched.push_back(d);
                    for (int s = 1; s <= k; s++) begin
                        d = '0;
                        d.st = 3'(s);
                        d.act = 1;
                        d.hchk = (s == k) && (p == np - 1) && (c % 2 == 1);
                        sched.push_back(d);
                    end
                end
                d = '0;
                d.fin = 1;
                d.eor = (c == ce - 1);
                sched.push_back(d);
            end
        d = '0;
        d.dn = 1;
        sched.push_back(d);
    endtask

    task automatic model_edge();
        if (!m_busy) begin
            if (bus.start) begin
                model_build(bus.cfg_kernel5, int'(bus.cfg_cols), int'(bus.cfg_rows));
                cur = sched.pop_front();
                m_busy = 1;
            end
        end else if (cur.hchk && bus.pe_fifo_full) begin
            cur = '0;
            cur.hchk = 1;
        end else if (sched.size() == 0) begin
            m_busy = 0;
            cur = '0;
        end else begin
            cur = sched.pop_front();
        end
        if (cur.ld) begin
            last_mode = cur.mode;
            last_sel = cur.sel;
        end
    endtask

    function automatic logic [31:0] exp_vec();
        return 32'({m_busy, cur.dn, cur.st, last_mode, cur.fin, cur.eor,
                    cur.act, cur.ld, last_sel});
    endfunction

    function automatic logic [31:0] obs_vec();
        return 32'({bus.busy, bus.done, bus.pe_state, bus.pe_weight_mode,
                    bus.pe_finish, bus.pe_end_of_row, bus.act_rd_en,
                    bus.wgt_rd_en, bus.wgt_sel});
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check(tag, obs_vec(), exp_vec());
    endtask

    // Runs one job from its start pulse until the model goes idle.
    // fmode: 0 full low, 1 random full, 2 fixed stall pattern.
    task automatic job(input string tag, input bit k5, input int cols,
                       input int rows, input int fmode, input bit restart);
        bus.start = 1;
        bus.cfg_kernel5 = k5;
        bus.cfg_cols = 8'(cols);
        bus.cfg_rows = 8'(rows);
        bus.pe_fifo_full = 0;
        step(tag);
        bus.start = 0;
        cyc = 1; fins = 0; acts = 0;
        first_fin = -1; last_fin = -1; done_cyc = -1;
        while (m_busy && cyc < 3000) begin
            if (bus.pe_finish) begin
                fins++;
                if (first_fin < 0) first_fin = cyc;
                last_fin = cyc;
            end
            if (bus.act_rd_en) acts++;
            if (bus.done) done_cyc = cyc;
            bus.start = restart && (cyc == 3);
            bus.cfg_kernel5 = ~k5;
            bus.cfg_cols = 8'(cols + 1);
            bus.cfg_rows = 8'(rows + 2);
            case (fmode)
                1: bus.pe_fifo_full = ($urandom_range(0, 2) == 0);
                2: bus.pe_fifo_full = (cyc >= 2 && cyc <= 4) || (cyc >= 9 && cyc <= 11);
                default: bus.pe_fifo_full = 0;
            endcase
            step(tag);
            cyc++;
        end
        bus.start = 0;
        bus.pe_fifo_full = 0;
        if (m_busy) check({tag, "_timeout"}, 1, 0);
        step({tag, "_idle"});
    endtask

    initial begin
        int ce, re;
        model_reset();
        bus.start = 0;
        bus.cfg_kernel5 = 0;
        bus.cfg_cols = '0;
        bus.cfg_rows = '0;
        bus.pe_fifo_full = 0;
        #12;
        check("reset", obs_vec(), 32'd0);
        rst_n = 1;
        step("idle");

        job("k3_2x1", 0, 2, 1, 0, 0);
        check("k3_fin1", 32'(first_fin), 32'd5);
        check("k3_fin2", 32'(last_fin), 32'd10);
        check("k3_done", 32'(done_cyc), 32'd11);
        check("k3_acts", 32'(acts), 32'd6);

        job("k5_2x1", 1, 2, 1, 0, 0);
        check("k5_acts", 32'(acts), 32'd20);
        check("k5_fins", 32'(fins), 32'd2);

        job("k3_stall", 0, 4, 1, 2, 0);
        check("stall_fin2", 32'(last_fin >= 0 ? 1 : 0), 32'd1);
        check("stall_fin1", 32'(first_fin), 32'd5);

        job("zero", 0, 0, 0, 0, 0);
        check("zero_fins", 32'(fins), 32'd1);

        job("restart", 0, 3, 2, 0, 1);
        check("restart_fins", 32'(fins), 32'd6);

        // Abort during RUN of the second row.
        bus.start = 1;
        bus.cfg_kernel5 = 0;
        bus.cfg_cols = 8'd2;
        bus.cfg_rows = 8'd3;
        step("abort_start");
        bus.start = 0;
        for (int i = 0; i < 12; i++) step("abort_run");
        check("abort_in_run", 32'(bus.act_rd_en), 32'd1);
        #2 rst_n = 0;
        #1;
        check("abort_out", obs_vec(), 32'd0);
        model_reset();
        #2 rst_n = 1;
        for (int i = 0; i < 3; i++) step("abort_quiet");

        job("after_abort", 0, 2, 3, 0, 0);
        check("after_fins", 32'(fins), 32'd6);

        for (int j = 0; j < 10; j++) begin
            bit k5;
            int c, r;
            k5 = 1'($urandom_range(0, 1));
            c = $urandom_range(0, 4);
            r = $urandom_range(0, 3);
            job("rnd_job", k5, c, r, 1, 1'($urandom_range(0, 1)));
            ce = (c == 0) ? 1 : c;
            re = (r == 0) ? 1 : r;
            check("rnd_fins", 32'(fins), 32'(ce * re));
            check("rnd_acts", 32'(acts), 32'(ce * re * (k5 ? 10 : 3)));
        end

        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 7) == 0);
            bus.cfg_kernel5 = 1'($urandom_range(0, 1));
            bus.cfg_cols = 8'($urandom_range(0, 3));
            bus.cfg_rows = 8'($urandom_range(0, 2));
            bus.pe_fifo_full = ($urandom_range(0, 2) == 0);
            step("rnd_cyc");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
